loop_sched: RTL and testbench
=============================

// Module: loop_sched
// PURPOSE
//  Control-loop sequencer for the flight datapath.
//  - Runs MPU init once, then on every loop tick runs: sensor read -> pitch CORDIC
//    -> roll CORDIC -> complementary filter -> error -> PID -> PWM latch.
//  - Each stage waiting on a done has a timeout; overruns are counted; repeated
//    failures latch a motor-kill fault. Replaces the ad-hoc FSM in the top level.
// PARAMETERS
//  TICK_DIV      50000  clk cycles per loop tick (1 kHz at 50 MHz); >= 16
//  STAGE_TMO     40000  max cycles in a waiting state before a timeout; < TICK_DIV
//  MAX_FAULTS    3      consecutive aborted cycles before FAULT; 1..15
// PORTS
//  clk           in   1   system clock, 50 MHz
//  rst_n         in   1   asynchronous active-low reset
//  run_en        in   1   loop enable; sampled only in WAIT_TICK
//  init_start    out  1   1-cycle pulse: start MPU init
//  init_done     in   1   MPU init complete (level or pulse)
//  read_start    out  1   1-cycle pulse: start 14-byte MPU burst read
//  read_done     in   1   burst read complete
//  pitch_start   out  1   1-cycle pulse: start pitch CORDIC
//  pitch_done    in   1   pitch CORDIC complete
//  roll_start    out  1   1-cycle pulse: start roll CORDIC
//  roll_done     in   1   roll CORDIC complete
//  filt_en       out  1   1-cycle pulse: complementary filter update
//  err_en        out  1   1-cycle pulse: error/integral/derivative update
//  pid_en        out  1   1-cycle pulse: PID update
//  pwm_oe        out  1   1-cycle pulse: latch new duties into all four PWMs
//  motor_kill    out  1   high in FAULT; PWM blocks force 0 duty
//  overrun_cnt   out  8   ticks that arrived while a cycle was in progress; saturates at 255
//  sched_state   out  4   current state encoding (debug)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, tick counter 0, fault counter 0.
//  - State encoding: IDLE=0, INIT=1, WAIT_TICK=2, READ=3, PITCH=4, ROLL=5, FILT=6,
//    ERR=7, PID=8, PWM=9, FAULT=10.
//  - Tick counter: free-runs 0..TICK_DIV-1 from reset and is never gated.
//    tick = 1 for the cycle where the count wraps to 0.
//  - Start pulses: asserted in the same cycle the register moves into the
//    corresponding state (registered outputs), never in two consecutive cycles.
//  - IDLE -> INIT with init_start, on the first cycle out of reset.
//  - INIT: on init_done -> WAIT_TICK. On timeout -> IDLE (retry) and the fault
//    counter increments. MAX_FAULTS init failures -> FAULT.
//  - WAIT_TICK: on tick && run_en -> READ with read_start.
//  - READ / PITCH / ROLL: the stage timer clears on entry. The matching done
//    advances to the next state with the next start pulse; ROLL done -> FILT.
//  - FILT, ERR, PID, PWM: one cycle each, pulsing filt_en, err_en, pid_en,
//    pwm_oe in that order. Exit PWM -> WAIT_TICK and clear the fault counter.
//  - Fixed latency: roll_done to pwm_oe = 4 cycles.
//  - Timeout: stage timer == STAGE_TMO-1 with no done. Abort the cycle, pwm_oe is
//    not pulsed, fault counter +1. Go to WAIT_TICK, or to FAULT if the counter
//    reaches MAX_FAULTS.
//  - done and timeout in the same cycle: done wins; no fault is counted.
//  - done inputs are ignored outside their own waiting state.
//  - tick while state != WAIT_TICK: overrun_cnt +1 (saturating); the tick is
//    dropped, not queued.
//  - run_en low in WAIT_TICK: no new cycle starts. A cycle already in progress
//    runs to completion.
//  - FAULT: motor_kill = 1, no pulses are issued, terminal until rst_n.
//  - Reset mid-cycle: returns to IDLE immediately and init is rerun.
// CONFIGURATION
//  LOOP_SCHED_STATS_EN defined:
//    - Adds output last_cycle_len [15:0], reset 0.
//    - Holds the clk count from the read_start pulse to the pwm_oe pulse
//      inclusive, for the last completed cycle.
//    - Updated in the pwm_oe cycle; saturates at 16'hFFFF; unchanged by aborts.
//  LOOP_SCHED_STATS_EN undefined: the port and its counter are absent; all other
//  behaviour is identical.
// TESTING
//  1) TICK_DIV=100, STAGE_TMO=50, all dones 3 cycles after their start
//     -> one pwm_oe per 100 clk; filt/err/pid/pwm on 4 consecutive cycles;
//     overrun_cnt=0.
//  2) pitch_done withheld
//     -> timeout 50 cycles after pitch_start; no pwm_oe that cycle; next tick
//     retries. 3 consecutive -> sched_state=10, motor_kill=1, no further pulses.
//  3) read_done held off for 120 cycles (TICK_DIV=100, STAGE_TMO=150)
//     -> overrun_cnt=1; cycle completes normally; fault counter stays 0.
//  4) pitch_done asserted in the exact timeout cycle -> advances to ROLL, no fault.
//  5) rst_n low during ROLL -> all outputs 0 asynchronously; after release,
//     init_start pulses once.
//  6) [LOOP_SCHED_STATS_EN] dones 3 cycles after each start -> last_cycle_len = 16.

Source files
------------

// File: rtl/loop_sched_if.sv
// Handshake bundle between the loop sequencer and the flight datapath stages.
// LOOP_SCHED_STATS_EN adds the last_cycle_len statistics signal.
interface loop_sched_if;
    logic       run_en;
    logic       init_start;
    logic       init_done;
    logic       read_start;
    logic       read_done;
    logic       pitch_start;
    logic       pitch_done;
    logic       roll_start;
    logic       roll_done;
    logic       filt_en;
    logic       err_en;
    logic       pid_en;
    logic       pwm_oe;
    logic       motor_kill;
    logic [7:0] overrun_cnt;
    logic [3:0] sched_state;
`ifdef LOOP_SCHED_STATS_EN
    logic [15:0] last_cycle_len;
`endif

    modport master (
        input  run_en, init_done, read_done, pitch_done, roll_done,
        output init_start, read_start, pitch_start, roll_start,
        output filt_en, err_en, pid_en, pwm_oe, motor_kill, overrun_cnt, sched_state
`ifdef LOOP_SCHED_STATS_EN
        , output last_cycle_len
`endif
    );

    modport slave (
        output run_en, init_done, read_done, pitch_done, roll_done,
        input  init_start, read_start, pitch_start, roll_start,
        input  filt_en, err_en, pid_en, pwm_oe, motor_kill, overrun_cnt, sched_state
`ifdef LOOP_SCHED_STATS_EN
        , input last_cycle_len
`endif
    );
endinterface

// File: rtl/loop_sched.sv
// Control-loop sequencer: MPU init, then per tick read -> CORDICs -> filter -> PID -> PWM.
// Define LOOP_SCHED_STATS_EN to add last_cycle_len (read_start..pwm_oe cycle count).
module loop_sched #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned STAGE_TMO  = 40000,
    parameter int unsigned MAX_FAULTS = 3
) (
    input logic          clk,
    input logic          rst_n,
    loop_sched_if.master bus
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned TmoW  = $clog2(STAGE_TMO + 1);

    localparam int unsigned PInit  = 0;
    localparam int unsigned PRead  = 1;
    localparam int unsigned PPitch = 2;
    localparam int unsigned PRoll  = 3;
    localparam int unsigned PFilt  = 4;
    localparam int unsigned PErr   = 5;
    localparam int unsigned PPid   = 6;
    localparam int unsigned PPwm   = 7;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StInit     = 4'd1,
        StWaitTick = 4'd2,
        StRead     = 4'd3,
        StPitch    = 4'd4,
        StRoll     = 4'd5,
        StFilt     = 4'd6,
        StErr      = 4'd7,
        StPid      = 4'd8,
        StPwm      = 4'd9,
        StFault    = 4'd10
    } state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_cnt_q;
    logic [TmoW-1:0]  tmr_q, tmr_d;
    logic [3:0]       fault_q, fault_d;
    logic [7:0]       overrun_q;
    logic [7:0]       pulse_q, pulse_d;
    logic             motor_kill_q;
    logic             tick, tmo, abort, waiting;

    assign tick    = (tick_cnt_q == TickW'(TICK_DIV - 1));
    assign tmo     = (tmr_q == TmoW'(STAGE_TMO - 1));
    assign waiting = (state_q == StInit) || (state_q == StRead) ||
                     (state_q == StPitch) || (state_q == StRoll);

    // Free-running loop tick; never gated by the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TickW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= '0;
        end else if (tick && (state_q != StWaitTick) && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        pulse_d = '0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d        = StInit;
                pulse_d[PInit] = 1'b1;
            end
            StInit: begin
                if (bus.init_done) begin
                    state_d = StWaitTick;
                end else if (tmo) begin
                    state_d = StIdle;
                    abort   = 1'b1;
                end
            end
            StWaitTick: begin
                if (tick && bus.run_en) begin
                    state_d        = StRead;
                    pulse_d[PRead] = 1'b1;
                end
            end
            StRead: begin
                if (bus.read_done) begin
                    state_d         = StPitch;
                    pulse_d[PPitch] = 1'b1;
                end else if (tmo) begin
                    state_d = StWaitTick;
                    abort   = 1'b1;
                end
            end
            StPitch: begin
                if (bus.pitch_done) begin
                    state_d        = StRoll;
                    pulse_d[PRoll] = 1'b1;
                end else if (tmo) begin
                    state_d = StWaitTick;
                    abort   = 1'b1;
                end
            end
            StRoll: begin
                if (bus.roll_done) begin
                    state_d        = StFilt;
                    pulse_d[PFilt] = 1'b1;
                end else if (tmo) begin
                    state_d = StWaitTick;
                    abort   = 1'b1;
                end
            end
            StFilt: begin
                state_d       = StErr;
                pulse_d[PErr] = 1'b1;
            end
            StErr: begin
                state_d       = StPid;
                pulse_d[PPid] = 1'b1;
            end
            StPid: begin
                state_d       = StPwm;
                pulse_d[PPwm] = 1'b1;
            end
            StPwm: begin
                state_d = StWaitTick;
                fault_d = '0;
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StFault;
            end
        endcase
        // Aborts from any waiting state share the consecutive-failure counter.
        if (abort) begin
            fault_d = fault_q + 4'd1;
            if (fault_d >= 4'(MAX_FAULTS)) begin
                state_d = StFault;
            end
        end
    end

    // Stage timer restarts on every entry into a waiting state.
    assign tmr_d = (waiting && (state_d == state_q)) ? tmr_q + TmoW'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tmr_q        <= '0;
            fault_q      <= '0;
            pulse_q      <= '0;
            motor_kill_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            fault_q      <= fault_d;
            pulse_q      <= pulse_d;
            motor_kill_q <= (state_d == StFault);
        end
    end

    assign bus.init_start  = pulse_q[PInit];
    assign bus.read_start  = pulse_q[PRead];
    assign bus.pitch_start = pulse_q[PPitch];
    assign bus.roll_start  = pulse_q[PRoll];
    assign bus.filt_en     = pulse_q[PFilt];
    assign bus.err_en      = pulse_q[PErr];
    assign bus.pid_en      = pulse_q[PPid];
    assign bus.pwm_oe      = pulse_q[PPwm];
    assign bus.motor_kill  = motor_kill_q;
    assign bus.overrun_cnt = overrun_q;
    assign bus.sched_state = state_q;

`ifdef LOOP_SCHED_STATS_EN
    logic [15:0] cyc_q, cyc_d, len_q, len_d;

    // cyc_q holds the inclusive count since read_start as of the current cycle.
    always_comb begin
        cyc_d = cyc_q;
        len_d = len_q;
        if (pulse_d[PRead]) begin
            cyc_d = 16'd1;
        end else if (cyc_q != 16'hFFFF) begin
            cyc_d = cyc_q + 16'd1;
        end
        if (pulse_d[PPwm]) begin
            len_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            len_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            len_q <= len_d;
        end
    end

    assign bus.last_cycle_len = len_q;
`endif

endmodule

// File: tb/tb_loop_sched.sv
// Directed bench for loop_sched: stage responders with per-stage done delays and a
// pwm_oe latency scoreboard; dut_b uses a stage timeout longer than the tick period.
module tb_loop_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  loop_sched_if bus_a();
  loop_sched_if bus_b();

  loop_sched #(.TICK_DIV(100), .STAGE_TMO(50), .MAX_FAULTS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  loop_sched #(.TICK_DIV(100), .STAGE_TMO(150), .MAX_FAULTS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Done fires dly cycles after its start pulse; dly == 0 withholds it.
  task automatic resp(input logic start, input int dly, inout int cnt, output logic done);
    done = 1'b0;
    if (start) cnt = dly;
    else if (cnt > 0) begin
      cnt--;
      done = (cnt == 0);
    end
  endtask

  int in_dly_a = 3, rd_dly_a = 3, pt_dly_a = 3, rl_dly_a = 3;
  int in_c_a, rd_c_a, pt_c_a, rl_c_a;
  int exp_pwm_a[$];
  int pwm_t_a[$];
  int filt_t_a, err_t_a, pid_t_a, rs_t_a;
  int n_pulse_a, n_read_a, n_init_a;
  logic [7:0] cur_a, prev_a = 8'd0;

  int rd_dly_b = 120;
  int in_c_b, rd_c_b, pt_c_b, rl_c_b;
  int exp_pwm_b[$];
  int n_pwm_b, rs_t_b;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_c_a = 0; rd_c_a = 0; pt_c_a = 0; rl_c_a = 0;
        bus_a.init_done = 1'b0; bus_a.read_done = 1'b0;
        bus_a.pitch_done = 1'b0; bus_a.roll_done = 1'b0;
        exp_pwm_a.delete();
      end else begin
        resp(bus_a.init_start, in_dly_a, in_c_a, bus_a.init_done);
        resp(bus_a.read_start, rd_dly_a, rd_c_a, bus_a.read_done);
        resp(bus_a.pitch_start, pt_dly_a, pt_c_a, bus_a.pitch_done);
        resp(bus_a.roll_start, rl_dly_a, rl_c_a, bus_a.roll_done);
        if (bus_a.roll_done) exp_pwm_a.push_back(cyc + 4);
      end
      cur_a = {bus_a.init_start, bus_a.read_start, bus_a.pitch_start, bus_a.roll_start,
               bus_a.filt_en, bus_a.err_en, bus_a.pid_en, bus_a.pwm_oe};
      if (cur_a != 8'd0) chk("no_back_to_back_a", 32'(cur_a & prev_a), 32'd0);
      prev_a = cur_a;
      n_pulse_a += $countones(cur_a);
      if (bus_a.init_start) n_init_a++;
      if (bus_a.read_start) begin n_read_a++; rs_t_a = cyc; end
      if (bus_a.filt_en) filt_t_a = cyc;
      if (bus_a.err_en) err_t_a = cyc;
      if (bus_a.pid_en) pid_t_a = cyc;
      if (bus_a.pwm_oe) begin
        chk("pwm_expected_a", 32'(exp_pwm_a.size() > 0), 32'd1);
        if (exp_pwm_a.size() > 0) chk("pwm_latency_a", cyc, exp_pwm_a.pop_front());
        chk("filt_seq_a", filt_t_a, cyc - 3);
        chk("err_seq_a", err_t_a, cyc - 2);
        chk("pid_seq_a", pid_t_a, cyc - 1);
`ifdef LOOP_SCHED_STATS_EN
        chk("last_len_a", 32'(bus_a.last_cycle_len), cyc - rs_t_a + 1);
`endif
        pwm_t_a.push_back(cyc);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_c_b = 0; rd_c_b = 0; pt_c_b = 0; rl_c_b = 0;
        bus_b.init_done = 1'b0; bus_b.read_done = 1'b0;
        bus_b.pitch_done = 1'b0; bus_b.roll_done = 1'b0;
        exp_pwm_b.delete();
      end else begin
        resp(bus_b.init_start, 3, in_c_b, bus_b.init_done);
        resp(bus_b.read_start, rd_dly_b, rd_c_b, bus_b.read_done);
        resp(bus_b.pitch_start, 3, pt_c_b, bus_b.pitch_done);
        resp(bus_b.roll_start, 3, rl_c_b, bus_b.roll_done);
        if (bus_b.roll_done) exp_pwm_b.push_back(cyc + 4);
      end
      if (bus_b.read_start) rs_t_b = cyc;
      if (bus_b.pwm_oe) begin
        chk("pwm_expected_b", 32'(exp_pwm_b.size() > 0), 32'd1);
        if (exp_pwm_b.size() > 0) chk("pwm_latency_b", cyc, exp_pwm_b.pop_front());
`ifdef LOOP_SCHED_STATS_EN
        chk("last_len_b", 32'(bus_b.last_cycle_len), cyc - rs_t_b + 1);
`endif
        n_pwm_b++;
      end
    end
  end

  task automatic wait_pwm_a(input int n, input int budget);
    int k = 0;
    while (pwm_t_a.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("pwm_count_a", 32'(pwm_t_a.size()), 32'(n));
  endtask

  task automatic wait_pwm_b(input int n, input int budget);
    int k = 0;
    while (n_pwm_b < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("pwm_count_b", n_pwm_b, n);
  endtask

  task automatic wait_pitch_a(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_a.pitch_start && k < budget);
    chk("pitch_start_seen", 32'(bus_a.pitch_start), 32'd1);
  endtask

  initial begin
    int n0;
    int k;
    bus_a.run_en = 1'b1;
    bus_b.run_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state_a", 32'(bus_a.sched_state), 32'd0);
    chk("rst_pulses_a", 32'({bus_a.init_start, bus_a.read_start, bus_a.pwm_oe}), 32'd0);
    chk("rst_motor_kill_a", 32'(bus_a.motor_kill), 32'd0);
    chk("rst_overrun_a", 32'(bus_a.overrun_cnt), 32'd0);
    chk("rst_state_b", 32'(bus_b.sched_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_start_pulse", 32'(bus_a.init_start), 32'd1);
    chk("state_init", 32'(bus_a.sched_state), 32'd1);
    @(negedge clk);
    chk("init_start_once", 32'(bus_a.init_start), 32'd0);

    // Nominal loop: dones 3 cycles after each start.
    wait_pwm_a(3, 400);
    if (pwm_t_a.size() >= 3) begin
      chk("pwm_period_1", pwm_t_a[1] - pwm_t_a[0], 100);
      chk("pwm_period_2", pwm_t_a[2] - pwm_t_a[1], 100);
    end
    chk("overrun_nominal", 32'(bus_a.overrun_cnt), 32'd0);
`ifdef LOOP_SCHED_STATS_EN
    chk("last_len_16", 32'(bus_a.last_cycle_len), 32'd16);
`endif

    // run_en low holds off new cycles without counting overruns.
    bus_a.run_en = 1'b0;
    n0 = n_read_a;
    repeat (250) @(negedge clk);
    chk("run_en_low_no_read", n_read_a - n0, 0);
    chk("run_en_low_overrun", 32'(bus_a.overrun_cnt), 32'd0);
    chk("run_en_low_state", 32'(bus_a.sched_state), 32'd2);

    // pitch_done lands on the timeout cycle: done wins.
    pt_dly_a = 49;
    bus_a.run_en = 1'b1;
    wait_pitch_a(300);
    repeat (49) @(negedge clk);
    chk("tmo_edge_state", 32'(bus_a.sched_state), 32'd4);
    @(negedge clk);
    chk("done_wins_state", 32'(bus_a.sched_state), 32'd5);
    chk("done_wins_roll_start", 32'(bus_a.roll_start), 32'd1);
    pt_dly_a = 3;
    wait_pwm_a(pwm_t_a.size() + 1, 100);

    // Asynchronous reset during ROLL.
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_a.roll_start && k < 300);
    chk("roll_start_seen", 32'(bus_a.roll_start), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(bus_a.sched_state), 32'd0);
    chk("async_rst_pulses", 32'({bus_a.init_start, bus_a.read_start, bus_a.pitch_start,
                                 bus_a.roll_start, bus_a.filt_en, bus_a.err_en,
                                 bus_a.pid_en, bus_a.pwm_oe}), 32'd0);
    chk("async_rst_kill", 32'(bus_a.motor_kill), 32'd0);
    repeat (2) @(negedge clk);
    n0 = n_init_a;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("init_once_after_rst", n_init_a - n0, 1);
    chk("state_after_rst", 32'(bus_a.sched_state), 32'd2);

    // dut_b: read_done 120 cycles late straddles a tick.
    bus_b.run_en = 1'b1;
    wait_pwm_b(1, 400);
    chk("late_read_overrun", 32'(bus_b.overrun_cnt), 32'd1);
    chk("late_read_state", 32'(bus_b.sched_state), 32'd9);
    rd_dly_b = 3;
    wait_pwm_b(2, 300);
    chk("late_read_overrun_hold", 32'(bus_b.overrun_cnt), 32'd1);
    chk("late_read_no_kill", 32'(bus_b.motor_kill), 32'd0);
    bus_b.run_en = 1'b0;

    // Three consecutive pitch timeouts latch FAULT.
    wait_pwm_a(pwm_t_a.size() + 1, 200);
    pt_dly_a = 0;
    n0 = pwm_t_a.size();
    chk("overrun_before_fault", 32'(bus_a.overrun_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      wait_pitch_a(300);
      repeat (49) @(negedge clk);
      chk("tmo_pending_state", 32'(bus_a.sched_state), 32'd4);
      @(negedge clk);
      chk("tmo_abort_state", 32'(bus_a.sched_state), 32'(i < 2 ? 2 : 10));
    end
    chk("no_pwm_on_abort", 32'(pwm_t_a.size()), 32'(n0));
    chk("fault_motor_kill", 32'(bus_a.motor_kill), 32'd1);
    n0 = n_pulse_a;
    repeat (300) @(negedge clk);
    chk("fault_no_pulses", n_pulse_a - n0, 0);
    chk("fault_terminal", 32'(bus_a.sched_state), 32'd10);
    chk("scoreboard_drained_a", 32'(exp_pwm_a.size()), 32'd0);
    chk("scoreboard_drained_b", 32'(exp_pwm_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
